// File: rtl/nibble_serial_alu_pkg.sv
// nibble_serial_alu_pkg: shared op encodings, FSM states and B-side mux helper
package nibble_serial_alu_pkg;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_INC = 2'b10;
  localparam logic [1:0] ALU_DEC = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  function automatic logic [3:0] alu_d(input logic [3:0] b, input logic [1:0] s);
    return s == ALU_ADD ? b : s == ALU_SUB ? ~b : s == ALU_INC ? 4'h0 : 4'hF;
  endfunction
  function automatic logic d_msb(input logic b, input logic [1:0] s);
    return s == ALU_ADD ? b : s == ALU_SUB ? ~b : s == ALU_INC ? 1'b0 : 1'b1;
  endfunction
endpackage

// File: rtl/nibble_serial_alu_arthmetic_unit.sv
// arthmetic_unit: 4-bit adder slice with selectable B-side operand
module arthmetic_unit
  import nibble_serial_alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] s,
  input  logic       c_in,
  output logic [3:0] r,
  output logic       c_out
);
  logic [3:0] d;
  assign d = alu_d(b, s);
  assign {c_out, r} = {1'b0, a} + {1'b0, d} + {4'b0, c_in};
endmodule

// File: rtl/nibble_serial_alu.sv
// nibble_serial_alu: sequences a WIDTH-bit op through a 4-bit unit one nibble per cycle
module nibble_serial_alu
  import nibble_serial_alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic [1:0]           sel,
  input  logic                 c_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 c_out,
  output logic                 zero,
  output logic                 ovf
);
  localparam int W = 4 * NIBBLES;
  localparam int CW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t state, state_nx;
  logic [W-1:0] a_sh, b_sh, res_nx;
  logic [W+3:0] cat;
  logic [1:0] sel_q;
  logic carry, c_nib, last, accept;
  logic [CW-1:0] cnt;
  logic [3:0] r;
  arthmetic_unit u_unit (
    .a(a_sh[3:0]),
    .b(b_sh[3:0]),
    .s(sel_q),
    .c_in(carry),
    .r(r),
    .c_out(c_nib)
  );
  assign in_ready = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign accept = in_valid & in_ready;
  assign last = cnt == CW'(NIBBLES - 1);
  assign cat = {r, result};
  assign res_nx = cat[W+3:4];
  always_comb begin
    state_nx = state == S_IDLE ? (accept ? S_EXEC : S_IDLE) :
               state == S_EXEC ? (last ? S_DONE : S_EXEC) :
               (out_ready ? S_IDLE : S_DONE);
  end
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      sel_q <= ALU_ADD;
      carry <= 1'b0;
      cnt <= '0;
      result <= '0;
      c_out <= 1'b0;
      zero <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      a_sh <= op_a;
      b_sh <= op_b;
      sel_q <= sel;
      carry <= c_in;
      cnt <= '0;
    end else if (state == S_EXEC) begin
      a_sh <= a_sh >> 4;
      b_sh <= b_sh >> 4;
      carry <= c_nib;
      result <= res_nx;
      cnt <= last ? cnt : cnt + 1'b1;
      if (last) begin
        c_out <= c_nib;
        zero <= res_nx == '0;
        ovf <= (a_sh[3] == d_msb(b_sh[3], sel_q)) & (r[3] != a_sh[3]);
      end
    end
  end
endmodule
